// File: rtl/wide_add_sequencer_if.sv
// wide_add_sequencer_if
//   Bundles every non-clock signal of wide_add_sequencer: the request
//   channel, the per-slice link to the external 16-bit combinational adder,
//   and the result channel.
//
//   Request channel  : in_valid, in_ready, op_a, op_b, op_cin, op_sub
//   Adder link       : add_a, add_b, add_cin (to adder); add_sum, add_cout (from adder)
//   Result channel   : out_valid, out_ready, result, result_cout, overflow
//
//   slave  : the sequencer itself.
//   master : the environment (requester, adder and result consumer).
interface wide_add_sequencer_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_cin;
  logic          op_sub;

  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic          add_cin;
  logic [15:0]   add_sum;
  logic          add_cout;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          result_cout;
  logic          overflow;

  modport slave (
    input  in_valid, op_a, op_b, op_cin, op_sub,
    input  add_sum, add_cout,
    input  out_ready,
    output in_ready,
    output add_a, add_b, add_cin,
    output out_valid, result, result_cout, overflow
  );

  modport master (
    output in_valid, op_a, op_b, op_cin, op_sub,
    output add_sum, add_cout,
    output out_ready,
    input  in_ready,
    input  add_a, add_b, add_cin,
    input  out_valid, result, result_cout, overflow
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//   Multi-cycle wide-integer add/subtract controller placed in front of a
//   purely combinational 16-bit adder. One operand pair is accepted per
//   transaction; the adder is then driven one 16-bit slice per cycle, LSB
//   slice first, with the adder's carry-out chained into the next slice's
//   carry-in. The assembled W-bit result (W = 16*WORDS) is returned over a
//   valid/ready handshake. Only one transaction is in flight at a time.
//
//   Ports
//     clk    : clock, all state updates on the rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : wide_add_sequencer_if.slave
//              request  in_valid/in_ready, op_a, op_b, op_cin, op_sub
//              adder    add_a, add_b, add_cin -> adder; add_sum, add_cout <- adder
//              result   out_valid/out_ready, result, result_cout, overflow
//
//   Subtraction is A + ~B + 1, so result_cout = 1 means "no borrow".
module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wide_add_sequencer_if.slave   bus
);

  localparam int W  = 16 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement overflow of the full-width add: operands agree in sign
  // but the sum's sign differs. For subtraction b_msb is the sign of ~B.
  function automatic logic add_overflow(input logic a_msb,
                                        input logic b_msb,
                                        input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

  state_t                  state;
  logic [KW-1:0]           k;
  logic                    carry;
  logic [WORDS-1:0][15:0]  a_reg;
  logic [WORDS-1:0][15:0]  b_reg;
  logic [WORDS-1:0][15:0]  result_r;
  logic                    result_cout_r;
  logic                    overflow_r;
  logic                    out_valid_r;
  logic                    in_ready_r;

  logic [15:0]             add_a_c;
  logic [15:0]             add_b_c;
  logic                    add_cin_c;

  // Adder drive comes from registers only, so the op_* inputs may change
  // freely once a request has been taken.
  always_comb begin
    add_a_c   = 16'h0000;
    add_b_c   = 16'h0000;
    add_cin_c = 1'b0;
    if (state == RUN) begin
      add_a_c   = a_reg[k];
      add_b_c   = b_reg[k];
      add_cin_c = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      k             <= '0;
      carry         <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      result_r      <= '0;
      result_cout_r <= 1'b0;
      overflow_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      in_ready_r    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg      <= bus.op_a;
            b_reg      <= bus.op_sub ? ~bus.op_b : bus.op_b;
            carry      <= bus.op_sub ? 1'b1 : bus.op_cin;
            k          <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end

        RUN: begin
          result_r[k] <= bus.add_sum;
          carry       <= bus.add_cout;
          k           <= k + 1'b1;
          if (k == K_LAST) begin
            // Top slice: the adder's outputs now describe the whole word.
            result_cout_r <= bus.add_cout;
            overflow_r    <= add_overflow(a_reg[WORDS-1][15],
                                          b_reg[WORDS-1][15],
                                          bus.add_sum[15]);
            k             <= '0;
            out_valid_r   <= 1'b1;
            state         <= DONE;
          end
        end

        DONE: begin
          // in_ready stays low here, so a result handshake and a new
          // request can never coincide.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          k           <= '0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.add_a       = add_a_c;
  assign bus.add_b       = add_b_c;
  assign bus.add_cin     = add_cin_c;
  assign bus.out_valid   = out_valid_r;
  assign bus.result      = W'(result_r);
  assign bus.result_cout = result_cout_r;
  assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic clk;
  logic rst_n;

  wide_add_sequencer_if #(.WORDS(WORDS)) bus ();

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural stand-in for the combinational 16-bit adder.
  logic [16:0] adder_full;
  assign adder_full   = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'h0000, bus.add_cin};
  assign bus.add_sum  = adder_full[15:0];
  assign bus.add_cout = adder_full[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] r, input logic c, input logic o);
    exp_t e;
    e.res  = r;
    e.cout = c;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  // Monitor: every result handshake is compared against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result %h with no expectation queued", bus.result);
      end else begin
        e = sb.pop_front();
        chk("result",      bus.result,             e.res);
        chk("result_cout", W'(bus.result_cout),    W'(e.cout));
        chk("overflow",    W'(bus.overflow),       W'(e.ovf));
      end
    end
  end

  // Waits for in_ready, presents the request for one accepting edge.
  // Returns #1 after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk("issue_timeout", W'(bus.in_ready), W'(1));
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_cin   = cin;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < limit);
    if (!bus.out_valid) chk("valid_timeout", W'(bus.out_valid), W'(1));
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain", W'(sb.size()), W'(0));
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [3:0] cin_seq;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_cin    = 1'b0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", W'(bus.out_valid),   W'(0));
    chk("rst_result",    bus.result,          W'(0));
    chk("rst_cout",      W'(bus.result_cout), W'(0));
    chk("rst_ovf",       W'(bus.overflow),    W'(0));
    chk("rst_add_a",     W'(bus.add_a),       W'(0));
    chk("rst_add_b",     W'(bus.add_b),       W'(0));
    chk("rst_add_cin",   W'(bus.add_cin),     W'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    @(posedge clk); #1;

    // 1: carry ripples through every slice; latency check
    bus.out_ready = 1'b0;
    push(64'h0, 1'b1, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    cin_seq = 4'b1110;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("t1_add_cin_k%0d", s), W'(bus.add_cin), W'(cin_seq[s]));
      chk($sformatf("t1_not_valid_k%0d", s), W'(bus.out_valid), W'(0));
      chk($sformatf("t1_in_ready_k%0d", s), W'(bus.in_ready), W'(0));
    end
    @(negedge clk);
    chk("t1_latency_valid", W'(bus.out_valid), W'(1));
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    wait_drain(20);

    // 2: signed overflow into the sign bit
    bus.out_ready = 1'b1;
    push(64'h8000_0000_0000_0000, 1'b0, 1'b1);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_drain(20);

    // 3: subtract with borrow; op_cin is ignored
    push(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    issue(64'h5, 64'h7, 1'b1, 1'b1);
    @(negedge clk);
    chk("t3_add_a0",   W'(bus.add_a),   W'(16'h0005));
    chk("t3_add_b0",   W'(bus.add_b),   W'(16'hFFF8));
    chk("t3_add_cin0", W'(bus.add_cin), W'(1));
    wait_drain(20);

    // 4: output stall; requests during DONE are ignored
    bus.out_ready = 1'b0;
    push(64'h0000_0000_0002_0000, 1'b0, 1'b0);
    issue(64'h0001_FFFF, 64'h0, 1'b1, 1'b0);
    wait_valid(20);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.op_a     = 64'h1234;
      bus.op_b     = 64'h1;
      bus.op_sub   = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("t4_hold_ready_%0d", i), W'(bus.in_ready),  W'(0));
      chk($sformatf("t4_hold_valid_%0d", i), W'(bus.out_valid), W'(1));
      chk($sformatf("t4_hold_result_%0d", i), bus.result, 64'h0000_0000_0002_0000);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t4_ready_after_hs", W'(bus.in_ready),  W'(1));
    chk("t4_valid_after_hs", W'(bus.out_valid), W'(0));
    @(negedge clk);
    chk("t4_no_new_run", W'(bus.add_a), W'(0));
    chk("t4_still_idle", W'(bus.in_ready), W'(1));
    wait_drain(5);

    // 5: reset in the middle of RUN
    bus.out_ready = 1'b1;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_running_k2", W'(bus.add_a), W'(16'hFFFF));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid",  W'(bus.out_valid), W'(0));
    chk("t5_rst_result", bus.result,        W'(0));
    chk("t5_rst_add_a",  W'(bus.add_a),     W'(0));
    chk("t5_rst_add_b",  W'(bus.add_b),     W'(0));
    chk("t5_rst_cin",    W'(bus.add_cin),   W'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5_no_valid_%0d", i), W'(bus.out_valid), W'(0));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready_after_rst", W'(bus.in_ready), W'(1));
    chk("t5_no_valid_after",  W'(bus.out_valid), W'(0));
    @(posedge clk); #1;
    push(64'h3, 1'b0, 1'b0);
    issue(64'h1, 64'h2, 1'b0, 1'b0);
    wait_drain(20);

    // 6: back-to-back, second request held pending while the first runs
    bus.out_ready = 1'b1;
    push(64'h2, 1'b0, 1'b0);
    push(64'h4, 1'b0, 1'b0);
    issue(64'h1, 64'h1, 1'b0, 1'b0);
    bus.op_a     = 64'h2;
    bus.op_b     = 64'h2;
    bus.op_cin   = 1'b0;
    bus.op_sub   = 1'b0;
    bus.in_valid = 1'b1;
    wait_valid(20);
    @(negedge clk);
    chk("t6_pulse1_len",   W'(bus.out_valid), W'(0));
    chk("t6_ready_after1", W'(bus.in_ready),  W'(1));
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_second_taken", W'(bus.in_ready), W'(0));
    wait_valid(20);
    @(negedge clk);
    chk("t6_pulse2_len", W'(bus.out_valid), W'(0));
    wait_drain(5);

    chk("sb_empty_end", W'(sb.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle wide-integer adder/subtractor controller that sits directly upstream of the team's 16-bit Kogge-Stone adder.
- Accepts one wide operand pair per transaction and drives the adder one 16-bit slice per cycle, LSB slice first.
- Chains the adder's carry-out into the next slice's carry-in, assembles the wide result and returns it over a valid/ready handshake.
- The adder is purely combinational; this block owns all state and timing.

Parameters:
- WORDS, 4, number of 16-bit slices; operand width W = 16*WORDS; legal range 1..16.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request carries a valid operand pair.
- in_ready  output  1  block can accept a request.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- op_cin  input  1  carry-in for add; ignored when op_sub=1.
- op_sub  input  1  1 = compute A - B, 0 = compute A + B + op_cin.
- add_a  output  16  slice of A to the adder's a input.
- add_b  output  16  slice of effective B to the adder's b input.
- add_cin  output  1  carry to the adder's cin input.
- add_sum  input  16  adder sum output.
- add_cout  input  1  adder cout output.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  W  wide sum or difference.
- result_cout  output  1  final carry-out; for subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; slice counter=0; carry register=0; operand registers=0.
  - result=0, result_cout=0, overflow=0, out_valid=0.
  - in_ready=1 after release.
  - add_a, add_b and add_cin are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge, register op_a into a_reg and the effective B into b_reg (op_sub ? ~op_b : op_b).
  - Set carry register to (op_sub ? 1 : op_cin), clear the slice counter k, and go to RUN.
- RUN (k = 0..WORDS-1), one slice per cycle:
  - add_a = a_reg[16k+15:16k], add_b = b_reg[16k+15:16k], add_cin = carry register.
  - These outputs come combinationally from registers only, never from the op_* inputs.
  - At each edge: result[16k+15:16k] <= add_sum, carry <= add_cout, k <= k+1.
  - At the edge where k=WORDS-1: also capture result_cout <= add_cout.
  - At that same edge, capture overflow <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[15] != a_reg[W-1]), then go to DONE.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1; result, result_cout and overflow are held stable.
  - On out_ready=1 at an edge, go to IDLE.
  - in_ready=0, so no new request is accepted in the same cycle as the result handshake.
- Outside RUN: add_a=0, add_b=0, add_cin=0.
- Latency: request accepted at edge T0; slices driven in cycles T0+1 .. T0+WORDS; out_valid is high from the cycle after edge T0+WORDS. In other words, WORDS+1 cycles from acceptance to out_valid, and one request is in flight at a time.
- Handshake rules:
  - in_valid while in_ready=0 is ignored and does not affect state.
  - out_valid stays high until consumed; there is no timeout.
  - Simultaneous in_valid and out_ready in DONE: only the output handshake occurs.
- Result slices not yet written during RUN keep their previous values; consumers must read result only while out_valid=1.
- Width/wrap: result is W bits modulo 2^W; the slice counter wraps only via the state exit.
- WORDS=1: exactly one RUN cycle; behaviour is otherwise identical.
- Reset during RUN or DONE: the transaction is aborted, no out_valid pulse is produced, and all reset values apply immediately.

Test Plan:
1. WORDS=4; A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, op_cin=0, op_sub=0 -> add_cin sequence 0,1,1,1 across RUN; result=0x0, result_cout=1, overflow=0; out_valid first high 5 cycles after the accept edge.
2. A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, add -> result=0x8000_0000_0000_0000, result_cout=0, overflow=1.
3. A=0x5, B=0x7, op_sub=1, op_cin=1 (ignored) -> add_b slice0=0xFFF8, add_cin=1 first; result=0xFFFF_FFFF_FFFF_FFFE, result_cout=0, overflow=0.
4. A=0x0001_FFFF, B=0x0, op_cin=1 -> result=0x0000_0000_0002_0000, result_cout=0; hold out_ready=0 for 3 cycles -> result stable, in_ready=0, and a new in_valid pulse during DONE is not accepted; in_ready=1 the cycle after the out_ready handshake.
5. Start A=B=0xFFFF_FFFF_FFFF_FFFF; assert rst_n=0 during RUN slice k=2 -> out_valid stays 0, result=0, add_* = 0 immediately; after release in_ready=1 and a new request 1+2 yields result=0x3.
6. Back-to-back: two requests (1+1, then 2+2) with out_ready tied high -> results 0x2 then 0x4, each with out_valid high for exactly 1 cycle; the second accept occurs no earlier than the cycle after the first result handshake.
